// File: rtl/binary_encoder_4_2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | binary_encoder_4_2: registered priority encoder with valid/ready,     |
// | empty/multi-hot flags and a saturating multi-hot counter. Rev 1.0     |
// +----------------------------------------------------------------------+
module binary_encoder_4_2 #(
  parameter int IN_BITS  = 2,
  parameter int CNT_BITS = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [2**IN_BITS-1:0]   in,
  input  logic                    en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IN_BITS-1:0]      out,
  output logic                    out_zero,
  output logic                    out_multi,
  output logic [CNT_BITS-1:0]     err_count
);

  localparam int N = 2**IN_BITS;
  localparam logic [0:0] S_EMPTY = 1'b0;
  localparam logic [0:0] S_FULL  = 1'b1;
  localparam logic [CNT_BITS-1:0] c_cnt_max = {CNT_BITS{1'b1}};
  localparam logic [N-1:0]        c_one     = {{(N-1){1'b0}}, 1'b1};

  logic [0:0]          r_state;
  logic [IN_BITS-1:0]  r_out;
  logic                r_zero;
  logic                r_multi;
  logic [CNT_BITS-1:0] r_cnt;

  logic [N-1:0]        w_word;
  logic [IN_BITS-1:0]  w_idx;
  logic                w_zero;
  logic                w_multi;
  logic                w_accept;

  assign w_word  = en ? in : '0;
  assign w_zero  = (w_word == '0);
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign w_multi = |(w_word & (w_word - c_one));

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (w_word[i]) begin
        w_idx = i[IN_BITS-1:0];
      end
    end
  end

  assign out_valid = (r_state == S_FULL);
  assign in_ready  = !out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_out   <= '0;
      r_zero  <= 1'b0;
      r_multi <= 1'b0;
      r_cnt   <= '0;
    end else begin
      if (w_accept) begin
        r_state <= S_FULL;
        r_out   <= w_idx;
        r_zero  <= w_zero;
        r_multi <= w_multi;
        if (w_multi && (r_cnt != c_cnt_max)) begin
          r_cnt <= r_cnt + 1'b1;
        end
      end else if (out_ready) begin
        r_state <= S_EMPTY;
      end
    end
  end

  assign out       = r_out;
  assign out_zero  = r_zero;
  assign out_multi = r_multi;
  assign err_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_binary_encoder_4_2.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_binary_encoder_4_2: directed self-checking bench. Rev 1.0          |
// +----------------------------------------------------------------------+
module tb_binary_encoder_4_2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_word = 4'b0000;
  logic       en = 1'b1;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [1:0] out;
  logic       out_zero;
  logic       out_multi;
  logic [7:0] err_count;

  int checks   = 0;
  int failures = 0;
  int exp_cnt;

  binary_encoder_4_2 #(.IN_BITS(2), .CNT_BITS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in        (in_word),
    .en        (en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_zero  (out_zero),
    .out_multi (out_multi),
    .err_count (err_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic [1:0] e_out,
                           input logic e_zero, input logic e_multi);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_out"},   {30'd0, out},       {30'd0, e_out});
    check({tag, "_zero"},  {31'd0, out_zero},  {31'd0, e_zero});
    check({tag, "_multi"}, {31'd0, out_multi}, {31'd0, e_multi});
  endtask

  initial begin
    // Reset
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out",   {30'd0, out},       32'd0);
    check("rst_zero",  {31'd0, out_zero},  32'd0);
    check("rst_multi", {31'd0, out_multi}, 32'd0);
    check("rst_err",   {24'd0, err_count}, 32'd0);
    check("rst_ready", {31'd0, in_ready},  32'd1);

    // Round trip, back-to-back
    in_valid = 1'b1; en = 1'b1; out_ready = 1'b1;
    in_word = 4'b0001; tick(); check_res("rt0", 2'd0, 1'b0, 1'b0);
    in_word = 4'b0010; tick(); check_res("rt1", 2'd1, 1'b0, 1'b0);
    in_word = 4'b0100; tick(); check_res("rt2", 2'd2, 1'b0, 1'b0);
    in_word = 4'b1000; tick(); check_res("rt3", 2'd3, 1'b0, 1'b0);
    check("rt_err", {24'd0, err_count}, 32'd0);

    // Disable and empty
    en = 1'b0; in_word = 4'b0100; tick(); check_res("dis", 2'd0, 1'b1, 1'b0);
    en = 1'b1; in_word = 4'b0000; tick(); check_res("empty", 2'd0, 1'b1, 1'b0);
    check("empty_err", {24'd0, err_count}, 32'd0);
    in_valid = 1'b0; tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);

    // Multi-hot priority
    in_valid = 1'b1; in_word = 4'b0110; tick();
    check_res("mh0", 2'd2, 1'b0, 1'b1);
    check("mh0_err", {24'd0, err_count}, 32'd1);
    in_word = 4'b1011; tick();
    check_res("mh1", 2'd3, 1'b0, 1'b1);
    check("mh1_err", {24'd0, err_count}, 32'd2);
    in_valid = 1'b0; tick();
    check("mh_drain", {31'd0, out_valid}, 32'd0);

    // Backpressure
    in_valid = 1'b1; in_word = 4'b0010; tick();
    check_res("bp_load", 2'd1, 1'b0, 1'b0);
    in_word = 4'b1000; out_ready = 1'b0; #1;
    check("bp_ready0", {31'd0, in_ready}, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_res("bp_hold", 2'd1, 1'b0, 1'b0);
      check("bp_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1; #1;
    check("bp_ready1", {31'd0, in_ready}, 32'd1);
    tick();
    check_res("bp_next", 2'd3, 1'b0, 1'b0);
    in_valid = 1'b0; tick();
    check("bp_drain", {31'd0, out_valid}, 32'd0);
    check("bp_err", {24'd0, err_count}, 32'd2);

    // Saturation: counter starts at 2 here
    exp_cnt = 2;
    in_valid = 1'b1; in_word = 4'b1100;
    for (int k = 0; k < 260; k++) begin
      tick();
      if (exp_cnt < 255) exp_cnt++;
      check("sat_out", {30'd0, out}, 32'd3);
      check("sat_err", {24'd0, err_count}, exp_cnt);
    end
    check("sat_final", {24'd0, err_count}, 32'd255);
    in_valid = 1'b0; tick();

    // Reset mid-flow
    in_valid = 1'b1; in_word = 4'b0100; tick();
    check_res("mf_load", 2'd2, 1'b0, 1'b0);
    rst = 1'b1; in_word = 4'b1100; tick();
    rst = 1'b0; in_valid = 1'b0; #1;
    check("mf_valid", {31'd0, out_valid}, 32'd0);
    check("mf_err",   {24'd0, err_count}, 32'd0);
    check("mf_out",   {30'd0, out},       32'd0);
    check("mf_multi", {31'd0, out_multi}, 32'd0);
    check("mf_ready", {31'd0, in_ready},  32'd1);
    tick();
    check("mf_after", {31'd0, out_valid}, 32'd0);
    check("mf_after_err", {24'd0, err_count}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
